// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: load encodings, source indices and
// the control half of the MEM/WB pipeline register.
package writeback_stage_pkg;

    localparam int RD_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_type_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    // Raw funct3 is kept so undefined codes survive to the extractor.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [RD_W-1:0] rd_addr;
        logic [2:0]      load_type;
        logic [1:0]      addr_lo;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB bus: the MEM-side entry fields and the registered writeback outputs.
interface writeback_stage_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC)
);
    logic                 mem_valid;
    logic                 mem_reg_write;
    logic [4:0]           mem_rd_addr;
    logic [SELW-1:0]      mem_wb_sel;
    logic [2:0]           mem_load_type;
    logic [1:0]           mem_addr_lo;
    logic [NSRC*XLEN-1:0] mem_src_data;

    logic                 wb_valid;
    logic                 wb_reg_write;
    logic [4:0]           wb_rd_addr;
    logic [XLEN-1:0]      wb_data;

    modport master (
        output mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_addr_lo, mem_src_data,
        input  wb_valid, wb_reg_write, wb_rd_addr, wb_data
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_addr_lo, mem_src_data,
        output wb_valid, wb_reg_write, wb_rd_addr, wb_data
    );
endinterface

// File: rtl/writeback_stage_load_extract.sv
// Load data extraction: picks the addressed byte/half of the loaded word and
// sign- or zero-extends it; word loads and unknown funct3 pass the word through.
module load_extract
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      load_type_i,
    output logic [XLEN-1:0] data_o
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[{addr_lo_i, 3'b000} +: 8];
        // Halfword alignment comes from addr_lo[1] alone.
        half_sel = data_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (load_type_i)
            LB:      data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback source mux, load extraction and a
// retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NSRC    = 4,
    parameter int MEM_SRC = int'(WB_MEM),
    parameter int SELW    = $clog2(NSRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    writeback_stage_if.slave  bus,
    output logic [31:0]       retire_count
);

    mem_wb_ctrl_t         ctrl_q, ctrl_d;
    logic [SELW-1:0]      sel_q, sel_d;
    logic [NSRC*XLEN-1:0] src_q, src_d;
    logic [31:0]          retire_q, retire_d;
    logic                 retire_en;
    logic [XLEN-1:0]      src_sel;
    logic [XLEN-1:0]      load_data;

    always_comb begin
        ctrl_d = '{valid:     bus.mem_valid,
                   reg_write: bus.mem_reg_write,
                   rd_addr:   bus.mem_rd_addr,
                   load_type: bus.mem_load_type,
                   addr_lo:   bus.mem_addr_lo};
        sel_d  = bus.mem_wb_sel;
        src_d  = bus.mem_src_data;
    end

    // Flush overrides stall, so a held entry still leaves the stage and retires.
    assign retire_en = ctrl_q.valid & (~stall | flush);
    assign retire_d  = retire_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            sel_q  <= '0;
            src_q  <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
            sel_q  <= '0;
            src_q  <= '0;
        end else if (!stall) begin
            ctrl_q <= ctrl_d;
            sel_q  <= sel_d;
            src_q  <= src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (retire_en) begin
            retire_q <= retire_d;
        end
    end

    load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .data_i      (src_q[MEM_SRC*XLEN +: XLEN]),
        .addr_lo_i   (ctrl_q.addr_lo),
        .load_type_i (ctrl_q.load_type),
        .data_o      (load_data)
    );

    // Selects that name no source fall through to zero.
    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_q == SELW'(i)) begin
                src_sel = src_q[i*XLEN +: XLEN];
            end
        end
    end

    assign bus.wb_data      = (sel_q == SELW'(MEM_SRC)) ? load_data : src_sel;
    assign bus.wb_valid     = ctrl_q.valid;
    assign bus.wb_rd_addr   = ctrl_q.rd_addr;
    assign bus.wb_reg_write = ctrl_q.valid & ctrl_q.reg_write & (ctrl_q.rd_addr != '0);
    assign retire_count     = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed entries push hand-computed
// expectations, a monitor pops and compares one per clock edge.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int XLEN = 32;
    localparam int NSRC = 4;

    typedef struct {
        string       nm;
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] retire_count;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    writeback_stage_if #(.XLEN(XLEN), .NSRC(NSRC)) bus ();

    writeback_stage #(
        .XLEN    (XLEN),
        .NSRC    (NSRC),
        .MEM_SRC (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .bus          (bus),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: one expectation per clock edge whenever one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".valid"}, 32'(bus.wb_valid), 32'(e.v));
                chk({e.nm, ".reg_write"}, 32'(bus.wb_reg_write), 32'(e.rw));
                chk({e.nm, ".rd"}, 32'(bus.wb_rd_addr), 32'(e.rd));
                chk({e.nm, ".data"}, bus.wb_data, e.data);
                chk({e.nm, ".retire"}, retire_count, e.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic st, input logic fl,
                        input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] lo,
                        input logic ev, input logic erw, input logic [4:0] erd,
                        input logic [31:0] edata, input logic [31:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst               = r;
        stall             = st;
        flush             = fl;
        bus.mem_valid     = v;
        bus.mem_reg_write = rw;
        bus.mem_rd_addr   = rd;
        bus.mem_wb_sel    = sel;
        bus.mem_load_type = lt;
        bus.mem_addr_lo   = lo;
        e.nm = nm; e.v = ev; e.rw = erw; e.rd = erd; e.data = edata; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        stall             = 1'b0;
        flush             = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.mem_reg_write = 1'b0;
        bus.mem_rd_addr   = 5'd0;
        bus.mem_wb_sel    = 2'd0;
        bus.mem_load_type = 3'd0;
        bus.mem_addr_lo   = 2'd0;
        // Sources: ALU, MEM, PC+4, CSR.
        bus.mem_src_data  = {32'hCAFE_0003, 32'h0000_1004, 32'h8070_60F0, 32'h1111_1111};

        //    name          r  st fl v  rw rd     sel lt      lo    ev erw erd    data           cnt
        step("reset",      1, 0, 0, 1, 1, 5'd9,  1, LB,     2'd0, 0, 0, 5'd0,  32'h0,          32'd0);
        step("lb",         0, 0, 0, 1, 1, 5'd5,  1, LB,     2'd0, 1, 1, 5'd5,  32'hFFFF_FFF0,  32'd0);
        step("lhu",        0, 0, 0, 1, 1, 5'd6,  1, LHU,    2'd2, 1, 1, 5'd6,  32'h0000_8070,  32'd1);
        step("lh",         0, 0, 0, 1, 1, 5'd7,  1, LH,     2'd3, 1, 1, 5'd7,  32'hFFFF_8070,  32'd2);
        step("lbu_b3",     0, 0, 0, 1, 1, 5'd8,  1, LBU,    2'd3, 1, 1, 5'd8,  32'h0000_0080,  32'd3);
        step("lb_b1",      0, 0, 0, 1, 1, 5'd9,  1, LB,     2'd1, 1, 1, 5'd9,  32'h0000_0060,  32'd4);
        step("lw",         0, 0, 0, 1, 1, 5'd10, 1, LW,     2'd2, 1, 1, 5'd10, 32'h8070_60F0,  32'd5);
        step("undef_f3",   0, 0, 0, 1, 1, 5'd11, 1, 3'b111, 2'd1, 1, 1, 5'd11, 32'h8070_60F0,  32'd6);
        step("alu",        0, 0, 0, 1, 1, 5'd12, 0, LB,     2'd1, 1, 1, 5'd12, 32'h1111_1111,  32'd7);
        step("pc4",        0, 0, 0, 1, 1, 5'd13, 2, LB,     2'd0, 1, 1, 5'd13, 32'h0000_1004,  32'd8);
        step("csr",        0, 0, 0, 1, 1, 5'd14, 3, LB,     2'd0, 1, 1, 5'd14, 32'hCAFE_0003,  32'd9);
        step("rd0",        0, 0, 0, 1, 1, 5'd0,  0, LB,     2'd0, 1, 0, 5'd0,  32'h1111_1111,  32'd10);
        step("no_rw",      0, 0, 0, 1, 0, 5'd3,  2, LB,     2'd0, 1, 0, 5'd3,  32'h0000_1004,  32'd11);
        step("bubble_in",  0, 0, 0, 0, 1, 5'd4,  0, LB,     2'd0, 0, 0, 5'd4,  32'h1111_1111,  32'd12);
        step("stall_ld",   0, 0, 0, 1, 1, 5'd20, 1, LBU,    2'd0, 1, 1, 5'd20, 32'h0000_00F0,  32'd12);
        step("stall1",     0, 1, 0, 1, 1, 5'd21, 0, LB,     2'd0, 1, 1, 5'd20, 32'h0000_00F0,  32'd12);
        step("stall2",     0, 1, 0, 1, 1, 5'd21, 0, LB,     2'd0, 1, 1, 5'd20, 32'h0000_00F0,  32'd12);
        step("stall3",     0, 1, 0, 1, 1, 5'd21, 0, LB,     2'd0, 1, 1, 5'd20, 32'h0000_00F0,  32'd12);
        step("unstall",    0, 0, 0, 1, 1, 5'd21, 0, LB,     2'd0, 1, 1, 5'd21, 32'h1111_1111,  32'd13);
        step("flush_stall",0, 1, 1, 1, 1, 5'd22, 1, LB,     2'd0, 0, 0, 5'd0,  32'h0,          32'd14);
        step("after_flush",0, 0, 0, 1, 1, 5'd23, 2, LB,     2'd0, 1, 1, 5'd23, 32'h0000_1004,  32'd14);

        @(negedge clk);
        force dut.retire_q = 32'hFFFF_FFFF;
        step("wrap_hold",  0, 1, 0, 1, 1, 5'd24, 3, LB,     2'd0, 1, 1, 5'd23, 32'h0000_1004,  32'hFFFF_FFFF);
        @(posedge clk);
        #2;
        release dut.retire_q;
        step("wrap",       0, 0, 0, 1, 1, 5'd24, 3, LB,     2'd0, 1, 1, 5'd24, 32'hCAFE_0003,  32'd0);
        step("more",       0, 0, 0, 1, 1, 5'd25, 0, LB,     2'd0, 1, 1, 5'd25, 32'h1111_1111,  32'd1);
        step("stall_a",    0, 1, 0, 1, 1, 5'd27, 1, LB,     2'd0, 1, 1, 5'd25, 32'h1111_1111,  32'd1);
        step("rst_mid",    1, 1, 0, 1, 1, 5'd27, 1, LB,     2'd0, 0, 0, 5'd0,  32'h0,          32'd0);
        step("rst_flush",  1, 0, 1, 1, 1, 5'd28, 1, LB,     2'd0, 0, 0, 5'd0,  32'h0,          32'd0);
        step("post_rst",   0, 0, 0, 1, 1, 5'd26, 1, LW,     2'd0, 1, 1, 5'd26, 32'h8070_60F0,  32'd0);
        step("final",      0, 0, 0, 0, 0, 5'd0,  0, LB,     2'd0, 0, 0, 5'd0,  32'h1111_1111,  32'd1);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
